// File: rtl/rggen_apb_master_bridge.sv
// APB requester: turns each accepted local command into one APB transfer and
// returns read data and status on a valid/ready response port.
module rggen_apb_master_bridge #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDRESS_WIDTH  = 16,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      i_command_valid,
  output logic                      o_command_ready,
  input  logic                      i_write,
  input  logic [ADDRESS_WIDTH-1:0]  i_address,
  input  logic [DATA_WIDTH-1:0]     i_write_data,
  input  logic [DATA_WIDTH-1:0]     i_write_mask,
  output logic                      o_response_valid,
  input  logic                      i_response_ready,
  output logic [DATA_WIDTH-1:0]     o_read_data,
  output logic [1:0]                o_status,
  output logic                      o_psel,
  output logic                      o_penable,
  output logic                      o_pwrite,
  output logic [ADDRESS_WIDTH-1:0]  o_paddr,
  output logic [2:0]                o_pprot,
  output logic [DATA_WIDTH-1:0]     o_pwdata,
  output logic [DATA_WIDTH/8-1:0]   o_pstrb,
  input  logic                      i_pready,
  input  logic [DATA_WIDTH-1:0]     i_prdata,
  input  logic                      i_pslverr
);

  localparam int          STROBE_WIDTH    = DATA_WIDTH / 8;
  localparam bit          TIMEOUT_ENABLED = (TIMEOUT_CYCLES != 0);
  localparam logic [15:0] TIMEOUT_LAST    = TIMEOUT_ENABLED ? 16'(TIMEOUT_CYCLES - 1) : 16'hFFFF;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS,
    RESPONSE
  } state_e;

  state_e                  state;
  state_e                  state_next;
  logic [15:0]             wait_count;
  logic [STROBE_WIDTH-1:0] strobe;
  logic                    command_accept;
  logic                    timeout_hit;

  // A byte lane is strobed when any bit of its mask byte is set.
  always_comb begin
    strobe = '0;
    for (int n = 0; n < STROBE_WIDTH; n++) begin
      strobe[n] = |i_write_mask[8*n +: 8];
    end
  end

  assign command_accept = (state == IDLE) && i_command_valid;
  assign timeout_hit    = TIMEOUT_ENABLED && (wait_count == TIMEOUT_LAST) && !i_pready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next       = state;
    o_command_ready  = 1'b0;
    o_psel           = 1'b0;
    o_penable        = 1'b0;
    o_response_valid = 1'b0;
    o_pprot          = 3'b000;
    case (state)
      IDLE: begin
        o_command_ready = 1'b1;
        if (i_command_valid) begin
          state_next = SETUP;
        end
      end
      SETUP: begin
        o_psel     = 1'b1;
        state_next = ACCESS;
      end
      ACCESS: begin
        o_psel    = 1'b1;
        o_penable = 1'b1;
        if (i_pready || timeout_hit) begin
          state_next = RESPONSE;
        end
      end
      RESPONSE: begin
        o_response_valid = 1'b1;
        if (i_response_ready) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // APB request fields are only loaded on acceptance and otherwise hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_pwrite <= 1'b0;
      o_paddr  <= '0;
      o_pwdata <= '0;
      o_pstrb  <= '0;
    end else if (command_accept) begin
      o_pwrite <= i_write;
      o_paddr  <= i_address;
      o_pwdata <= i_write ? i_write_data : '0;
      o_pstrb  <= i_write ? strobe : '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_count <= '0;
    end else if (state != ACCESS) begin
      wait_count <= '0;
    end else if (!i_pready && (wait_count != 16'hFFFF)) begin
      wait_count <= wait_count + 16'd1;
    end
  end

  // A completion on the last allowed cycle takes priority over the timeout.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_read_data <= '0;
      o_status    <= 2'b00;
    end else if (state == ACCESS) begin
      if (i_pready) begin
        o_read_data <= o_pwrite ? '0 : i_prdata;
        o_status    <= {1'b0, i_pslverr};
      end else if (timeout_hit) begin
        o_read_data <= '0;
        o_status    <= 2'b11;
      end
    end
  end

endmodule

// File: tb/tb_rggen_apb_master_bridge.sv
// Bench for rggen_apb_master_bridge: directed vector table, randomized vectors
// against a transaction-level model, and an asynchronous reset sequence.
module tb_rggen_apb_master_bridge;

  localparam int DW      = 32;
  localparam int AW      = 16;
  localparam int SW      = DW / 8;
  localparam int TIMEOUT = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          i_command_valid;
  logic          o_command_ready;
  logic          i_write;
  logic [AW-1:0] i_address;
  logic [DW-1:0] i_write_data;
  logic [DW-1:0] i_write_mask;
  logic          o_response_valid;
  logic          i_response_ready;
  logic [DW-1:0] o_read_data;
  logic [1:0]    o_status;
  logic          o_psel;
  logic          o_penable;
  logic          o_pwrite;
  logic [AW-1:0] o_paddr;
  logic [2:0]    o_pprot;
  logic [DW-1:0] o_pwdata;
  logic [SW-1:0] o_pstrb;
  logic          i_pready;
  logic [DW-1:0] i_prdata;
  logic          i_pslverr;

  rggen_apb_master_bridge #(
    .DATA_WIDTH     (DW),
    .ADDRESS_WIDTH  (AW),
    .TIMEOUT_CYCLES (TIMEOUT)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .i_command_valid  (i_command_valid),
    .o_command_ready  (o_command_ready),
    .i_write          (i_write),
    .i_address        (i_address),
    .i_write_data     (i_write_data),
    .i_write_mask     (i_write_mask),
    .o_response_valid (o_response_valid),
    .i_response_ready (i_response_ready),
    .o_read_data      (o_read_data),
    .o_status         (o_status),
    .o_psel           (o_psel),
    .o_penable        (o_penable),
    .o_pwrite         (o_pwrite),
    .o_paddr          (o_paddr),
    .o_pprot          (o_pprot),
    .o_pwdata         (o_pwdata),
    .o_pstrb          (o_pstrb),
    .i_pready         (i_pready),
    .i_prdata         (i_prdata),
    .i_pslverr        (i_pslverr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          write;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] mask;
    int            waits;
    logic          err;
    logic [DW-1:0] rdata;
    int            delay;
    logic [SW-1:0] expStrb;
    logic [1:0]    expStatus;
    logic [DW-1:0] expData;
    int            expPen;
  } vec_t;

  int vectors     = 0;
  int miscompares = 0;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  function automatic vec_t mkVec(input logic write, input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                                 input logic [DW-1:0] mask, input int waits, input logic err,
                                 input logic [DW-1:0] rdata, input int delay, input logic [SW-1:0] expStrb,
                                 input logic [1:0] expStatus, input logic [DW-1:0] expData, input int expPen);
    vec_t v;
    v.write = write; v.addr = addr; v.wdata = wdata; v.mask = mask;
    v.waits = waits; v.err = err; v.rdata = rdata; v.delay = delay;
    v.expStrb = expStrb; v.expStatus = expStatus; v.expData = expData; v.expPen = expPen;
    return v;
  endfunction

  // Transaction-level expectation: a completer that waits 'waits' cycles
  // answers on enable cycle waits+1 unless that exceeds the timeout budget.
  function automatic vec_t modelResponse(input vec_t vin);
    vec_t v;
    bit   timedOut;
    v = vin;
    timedOut = (TIMEOUT != 0) && (v.waits >= TIMEOUT);
    for (int b = 0; b < SW; b++) begin
      v.expStrb[b] = v.write && (v.mask[8*b +: 8] != 8'h00);
    end
    if (timedOut) begin
      v.expStatus = 2'b11;
      v.expData   = '0;
      v.expPen    = TIMEOUT;
    end else begin
      v.expStatus = {1'b0, v.err};
      v.expData   = v.write ? '0 : v.rdata;
      v.expPen    = v.waits + 1;
    end
    return v;
  endfunction

  task automatic applyStimulus(input vec_t v, input string tag);
    int            pen;
    int            cycles;
    bit            stable;
    bit            respStable;
    logic [DW-1:0] expWdata;
    expWdata = v.write ? v.wdata : '0;

    checkOutput({tag, " idle ready"}, 64'(o_command_ready), 64'(1));
    i_command_valid = 1'b1;
    i_write         = v.write;
    i_address       = v.addr;
    i_write_data    = v.wdata;
    i_write_mask    = v.mask;
    i_pready        = 1'b0;
    @(posedge clk); #1;
    cycles = 1;

    // SETUP: scramble command and APB inputs, they must be ignored here
    i_command_valid = 1'($urandom_range(0, 1));
    i_write         = ~v.write;
    i_address       = AW'($urandom);
    i_write_data    = DW'($urandom);
    i_write_mask    = DW'($urandom);
    i_pready        = 1'b1;
    i_prdata        = DW'($urandom);
    i_pslverr       = 1'($urandom_range(0, 1));
    checkOutput({tag, " setup psel"}, 64'(o_psel), 64'(1));
    checkOutput({tag, " setup penable"}, 64'(o_penable), 64'(0));
    checkOutput({tag, " setup paddr"}, 64'(o_paddr), 64'(v.addr));
    checkOutput({tag, " setup pwrite"}, 64'(o_pwrite), 64'(v.write));
    checkOutput({tag, " setup pwdata"}, 64'(o_pwdata), 64'(expWdata));
    checkOutput({tag, " setup pstrb"}, 64'(o_pstrb), 64'(v.expStrb));
    checkOutput({tag, " setup cmd ready"}, 64'(o_command_ready), 64'(0));
    @(posedge clk); #1;
    cycles++;

    pen    = 0;
    stable = 1'b1;
    while (o_penable && pen < 300) begin
      pen++;
      if (o_psel !== 1'b1 || o_paddr !== v.addr || o_pwrite !== v.write ||
          o_pwdata !== expWdata || o_pstrb !== v.expStrb) begin
        stable = 1'b0;
      end
      i_pready  = (pen == v.waits + 1);
      i_prdata  = v.rdata;
      i_pslverr = v.err;
      @(posedge clk); #1;
      cycles++;
    end
    checkOutput({tag, " penable cycles"}, 64'(pen), 64'(v.expPen));
    checkOutput({tag, " access stable"}, 64'(stable), 64'(1));

    // RESPONSE: keep a distinct command pending; it must not be taken early
    i_pready         = 1'($urandom_range(0, 1));
    i_prdata         = DW'($urandom);
    i_pslverr        = 1'($urandom_range(0, 1));
    i_command_valid  = 1'b1;
    i_write          = ~v.write;
    i_address        = v.addr ^ AW'(16'h0100);
    i_response_ready = 1'b0;
    checkOutput({tag, " resp valid"}, 64'(o_response_valid), 64'(1));
    checkOutput({tag, " resp psel"}, 64'(o_psel | o_penable), 64'(0));
    checkOutput({tag, " resp data"}, 64'(o_read_data), 64'(v.expData));
    checkOutput({tag, " resp status"}, 64'(o_status), 64'(v.expStatus));
    checkOutput({tag, " resp cmd ready"}, 64'(o_command_ready), 64'(0));
    respStable = 1'b1;
    for (int d = 0; d < v.delay; d++) begin
      @(posedge clk); #1;
      cycles++;
      i_pready = 1'($urandom_range(0, 1));
      i_prdata = DW'($urandom);
      if (o_response_valid !== 1'b1 || o_read_data !== v.expData || o_status !== v.expStatus ||
          o_command_ready !== 1'b0 || o_psel !== 1'b0) begin
        respStable = 1'b0;
      end
    end
    checkOutput({tag, " resp held"}, 64'(respStable), 64'(1));
    i_response_ready = 1'b1;
    @(posedge clk); #1;
    cycles++;
    i_response_ready = 1'b0;
    i_command_valid  = 1'b0;
    i_pready         = 1'b0;
    checkOutput({tag, " resp done"}, 64'(o_response_valid), 64'(0));
    checkOutput({tag, " back idle"}, 64'(o_command_ready), 64'(1));
    checkOutput({tag, " total cycles"}, 64'(cycles), 64'(3 + v.expPen + v.delay));
    checkOutput({tag, " paddr held"}, 64'(o_paddr), 64'(v.addr));
  endtask

  vec_t directed[8];
  vec_t rv;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    rst_n            = 1'b0;
    i_command_valid  = 1'b0;
    i_write          = 1'b0;
    i_address        = '0;
    i_write_data     = '0;
    i_write_mask     = '0;
    i_response_ready = 1'b0;
    i_pready         = 1'b0;
    i_prdata         = '0;
    i_pslverr        = 1'b0;

    directed[0] = mkVec(1'b1, 16'h0010, 32'hA5A5_1234, 32'h00FF_FF00, 0, 1'b0, 32'h0, 0, 4'b0110, 2'b00, 32'h0, 1);
    directed[1] = mkVec(1'b0, 16'h0020, 32'h0, 32'hFFFF_FFFF, 3, 1'b0, 32'hDEAD_BEEF, 0, 4'b0000, 2'b00, 32'hDEAD_BEEF, 4);
    directed[2] = mkVec(1'b0, 16'h0030, 32'h1111_1111, 32'hFFFF_FFFF, 0, 1'b1, 32'h1234_5678, 0, 4'b0000, 2'b01, 32'h1234_5678, 1);
    directed[3] = mkVec(1'b0, 16'h0040, 32'h0, 32'h0, 20, 1'b0, 32'h5555_5555, 0, 4'b0000, 2'b11, 32'h0, 8);
    directed[4] = mkVec(1'b0, 16'h0044, 32'h0, 32'h0, 7, 1'b0, 32'hCAFE_F00D, 1, 4'b0000, 2'b00, 32'hCAFE_F00D, 8);
    directed[5] = mkVec(1'b1, 16'h0050, 32'h0123_4567, 32'hFF00_0001, 2, 1'b0, 32'hFFFF_FFFF, 5, 4'b1001, 2'b00, 32'h0, 3);
    directed[6] = mkVec(1'b1, 16'h0054, 32'h89AB_CDEF, 32'h0000_FF00, 1, 1'b1, 32'hFFFF_FFFF, 0, 4'b0010, 2'b01, 32'h0, 2);
    directed[7] = mkVec(1'b1, 16'h0058, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 8, 1'b0, 32'h0, 2, 4'b1111, 2'b11, 32'h0, 8);

    #2;
    checkOutput("reset cmd ready", 64'(o_command_ready), 64'(1));
    checkOutput("reset psel", 64'(o_psel), 64'(0));
    checkOutput("reset penable", 64'(o_penable), 64'(0));
    checkOutput("reset pwrite", 64'(o_pwrite), 64'(0));
    checkOutput("reset paddr", 64'(o_paddr), 64'(0));
    checkOutput("reset pwdata", 64'(o_pwdata), 64'(0));
    checkOutput("reset pstrb", 64'(o_pstrb), 64'(0));
    checkOutput("reset pprot", 64'(o_pprot), 64'(0));
    checkOutput("reset resp valid", 64'(o_response_valid), 64'(0));
    checkOutput("reset read data", 64'(o_read_data), 64'(0));
    checkOutput("reset status", 64'(o_status), 64'(0));
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 8; i++) begin
      applyStimulus(directed[i], $sformatf("dir%0d", i));
    end

    for (int i = 0; i < 40; i++) begin
      rv.write = 1'($urandom_range(0, 1));
      rv.addr  = AW'($urandom);
      rv.wdata = DW'($urandom);
      rv.mask  = DW'($urandom) & {{8{1'($urandom_range(0, 1))}}, {8{1'($urandom_range(0, 1))}},
                                   {8{1'($urandom_range(0, 1))}}, {8{1'($urandom_range(0, 1))}}};
      rv.waits = int'($urandom_range(0, 11));
      rv.err   = 1'($urandom_range(0, 1));
      rv.rdata = DW'($urandom);
      rv.delay = int'($urandom_range(0, 3));
      rv       = modelResponse(rv);
      applyStimulus(rv, $sformatf("rnd%0d", i));
    end

    // Reset asserted mid-ACCESS must clear the bus without a clock edge
    i_command_valid = 1'b1;
    i_write         = 1'b0;
    i_address       = 16'h0060;
    i_pready        = 1'b0;
    @(posedge clk); #1;
    i_command_valid = 1'b0;
    @(posedge clk); #1;
    checkOutput("rst pre penable", 64'(o_penable), 64'(1));
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("rst async psel", 64'(o_psel), 64'(0));
    checkOutput("rst async penable", 64'(o_penable), 64'(0));
    checkOutput("rst async resp valid", 64'(o_response_valid), 64'(0));
    checkOutput("rst async cmd ready", 64'(o_command_ready), 64'(1));
    checkOutput("rst async paddr", 64'(o_paddr), 64'(0));
    @(posedge clk); #1;
    rst_n = 1'b1;
    applyStimulus(mkVec(1'b0, 16'h0070, 32'h0, 32'h0, 1, 1'b0, 32'h0BAD_F00D, 0,
                        4'b0000, 2'b00, 32'h0BAD_F00D, 2), "post-rst");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/rggen_apb_master_bridge.md
Name: rggen_apb_master_bridge

Overview:
- APB initiator (requester) that takes single commands from a local valid/ready command port and drives one APB transfer per command.
- Returns read data and status on a valid/ready response port.
- Used where a local agent (debug bridge, test CPU model, register-access sequencer) must access an APB-attached register block.
- Adds an optional access timeout so a hung completer cannot stall the local side forever.

Parameters:
- DATA_WIDTH, 32: data width in bits; multiple of 8.
- ADDRESS_WIDTH, 16: APB address width.
- TIMEOUT_CYCLES, 256: maximum number of ACCESS-phase cycles without i_pready; 0 disables the timeout. Legal range 0..65535.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- i_command_valid  in  1  local command valid
- o_command_ready  out  1  command accepted when valid && ready
- i_write  in  1  1 = write, 0 = read
- i_address  in  ADDRESS_WIDTH  byte address
- i_write_data  in  DATA_WIDTH  write data
- i_write_mask  in  DATA_WIDTH  bit-granular write mask
- o_response_valid  out  1  response valid
- i_response_ready  in  1  response accepted when valid && ready
- o_read_data  out  DATA_WIDTH  read data; 0 for writes and timeouts
- o_status  out  2  bit0 = error, bit1 = timeout; 00 OK, 01 PSLVERR, 11 timeout
- o_psel  out  1  APB select
- o_penable  out  1  APB enable
- o_pwrite  out  1  APB direction
- o_paddr  out  ADDRESS_WIDTH  APB address
- o_pprot  out  3  constant 3'b000
- o_pwdata  out  DATA_WIDTH  APB write data
- o_pstrb  out  DATA_WIDTH/8  byte strobes
- i_pready  in  1  completer ready
- i_prdata  in  DATA_WIDTH  completer read data
- i_pslverr  in  1  completer error

Behaviour:
- Clocking and reset: single clock; every flop resets asynchronously on rst_n low.
- Reset values: state = IDLE; o_psel, o_penable, o_pwrite, o_paddr, o_pwdata, o_pstrb, o_response_valid, o_read_data, o_status all 0. o_command_ready = 1 immediately after reset (IDLE).
- FSM states: IDLE, SETUP, ACCESS, RESPONSE.
- IDLE:
  - o_command_ready = 1 combinationally from state.
  - On i_command_valid, capture i_write, i_address, i_write_data and the strobes into the APB output registers, then go to SETUP.
  - o_pstrb[n] = OR of i_write_mask[8n+7:8n]. For reads, o_pstrb = 0 and o_pwdata = 0.
- SETUP: o_psel = 1, o_penable = 0 for exactly one cycle, then go to ACCESS.
- ACCESS:
  - o_psel = 1, o_penable = 1.
  - On i_pready: capture read data (i_prdata for reads, 0 for writes) and status {1'b0, i_pslverr}, then go to RESPONSE.
  - Wait-state counter starts at 0 on entry and increments each cycle without i_pready.
  - If TIMEOUT_CYCLES != 0 and the counter reaches TIMEOUT_CYCLES - 1 with i_pready low: abort, capture status 2'b11 and read data 0, go to RESPONSE.
  - i_pready on the final allowed cycle wins over timeout.
- RESPONSE:
  - o_psel = 0, o_penable = 0; o_response_valid = 1.
  - Data and status are held stable until i_response_ready, then return to IDLE.
- APB output stability: o_paddr, o_pwrite, o_pwdata and o_pstrb are registered and stable from SETUP through ACCESS. They hold their last value after the transfer; they are not cleared.
- Throughput: minimum 4 cycles per command (IDLE accept, SETUP, ACCESS with zero wait, RESPONSE with i_response_ready high). No overlap or pipelining of commands.
- Input sampling: i_command_valid and the command fields are ignored outside IDLE. APB inputs are ignored outside ACCESS.
- Reset mid-transfer: o_psel and o_penable drop asynchronously, any pending response is discarded, and the FSM returns to IDLE.
- The wait-state counter is 16 bits and saturates; it cannot wrap.

Test Plan:
- Write 0xA5A5_1234 to 0x0010 with mask 0x00FF_FF00, i_pready tied high -> SETUP with paddr 0x0010, pstrb 4'b0110, pwrite 1; ACCESS one cycle later; response status 00, read data 0; 4 cycles total.
- Read 0x0020, completer inserts 3 wait states and returns 0xDEADBEEF -> penable high for 4 cycles; o_read_data 0xDEADBEEF, status 00; paddr stable throughout.
- Read with i_pslverr=1 when i_pready=1 -> status 01, read data = i_prdata as driven.
- TIMEOUT_CYCLES=8, i_pready held low -> penable high for exactly 8 cycles, then psel/penable drop; status 11, read data 0. Repeat with i_pready on the 8th cycle -> normal completion, status 00.
- Hold i_response_ready low 5 cycles in RESPONSE -> response valid, data and status stable; o_command_ready stays 0 and a pending command is not accepted until the handshake.
- Assert rst_n low during ACCESS -> psel, penable and response_valid go 0 without waiting for a clock edge; after release, command_ready = 1 and a new transfer completes normally.
